// File: rtl/rx_baud_if.sv
// ---------------------------------------------------------------------------
// rx_baud_if
// Bundle between the UART receive control logic and the Rx baud generator.
//   Enable_i   run the generator (0 = idle)
//   Divisor_i  clocks per acquisition tick (0 behaves as 1)
//   Resync_i   1-cycle pulse on a detected start edge
//   Halt_i     1-cycle pulse at end of frame, drops out of alignment
//   AcqSig_o   1-cycle acquisition tick
//   BitSig_o   1-cycle mid-bit sample strobe
//   Phase_o    oversample phase (aligned only, else 0)
//   Aligned_o  high while the generator is aligned to a start edge
// master drives the controls; slave is the generator side.
// ---------------------------------------------------------------------------
interface rx_baud_if #(
    parameter int DIV_W   = 16,
    parameter int PHASE_W = 4
);
    logic               Enable_i;
    logic [DIV_W-1:0]   Divisor_i;
    logic               Resync_i;
    logic               Halt_i;
    logic               AcqSig_o;
    logic               BitSig_o;
    logic [PHASE_W-1:0] Phase_o;
    logic               Aligned_o;

    modport master (
        output Enable_i, Divisor_i, Resync_i, Halt_i,
        input  AcqSig_o, BitSig_o, Phase_o, Aligned_o
    );

    modport slave (
        input  Enable_i, Divisor_i, Resync_i, Halt_i,
        output AcqSig_o, BitSig_o, Phase_o, Aligned_o
    );
endinterface

// File: rtl/rx_baud_gen.sv
// ---------------------------------------------------------------------------
// rx_baud_gen
// Timing stage of the UART receive path. A clock divider produces the
// acquisition tick AcqSig_o; after a start-edge resync an oversample phase
// counter additionally marks the middle of each bit with BitSig_o.
// States: IDLE (divisor latched every cycle), FREE (ticks only),
// ALIGNED (ticks plus phase counting and mid-bit strobes).
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  rx_baud_if slave: Enable_i, Divisor_i, Resync_i, Halt_i in;
//        AcqSig_o, BitSig_o, Phase_o, Aligned_o out (all registered)
// OVERSAMPLE must equal 2**PHASE_W so the phase counter wraps naturally.
// ---------------------------------------------------------------------------
module rx_baud_gen #(
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = 16,
    parameter int PHASE_W    = 4
) (
    input  logic      clk,
    input  logic      rst,
    rx_baud_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FREE    = 2'd1,
        ST_ALIGNED = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0]   DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [PHASE_W-1:0] PHASE_ONE = {{(PHASE_W-1){1'b0}}, 1'b1};
    // Phase value just before the tick that lands in the middle of the bit.
    localparam logic [PHASE_W-1:0] MID_PHASE = PHASE_W'(OVERSAMPLE/2 - 1);

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               acq_q, acq_d;
    logic               bit_q, bit_d;
    logic               aligned_q, aligned_d;
    logic               tick;

    assign tick = (cnt_q == (div_q - DIV_ONE));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            div_q     <= DIV_ONE;
            cnt_q     <= '0;
            phase_q   <= '0;
            acq_q     <= 1'b0;
            bit_q     <= 1'b0;
            aligned_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            acq_q     <= acq_d;
            bit_q     <= bit_d;
            aligned_q <= aligned_d;
        end
    end

    // Next-state logic. Enable low dominates; Resync beats Halt.
    always_comb begin
        state_d = state_q;
        if (!bus.Enable_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:    state_d = ST_FREE;
                ST_FREE:    if (bus.Resync_i) state_d = ST_ALIGNED;
                ST_ALIGNED: begin
                    if (bus.Resync_i)    state_d = ST_ALIGNED;
                    else if (bus.Halt_i) state_d = ST_FREE;
                end
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath / output next values
    always_comb begin
        div_d     = div_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        acq_d     = 1'b0;
        bit_d     = 1'b0;
        aligned_d = (state_d == ST_ALIGNED);
        unique case (state_q)
            ST_FREE, ST_ALIGNED: begin
                if (!bus.Enable_i) begin
                    cnt_d   = '0;
                    phase_d = '0;
                end else if (bus.Resync_i) begin
                    // A tick falling on this edge is dropped; restart the bit.
                    cnt_d   = '0;
                    phase_d = '0;
                end else begin
                    cnt_d = tick ? '0 : (cnt_q + DIV_ONE);
                    acq_d = tick;
                    if (state_q == ST_ALIGNED) begin
                        if (bus.Halt_i) begin
                            phase_d = '0;
                        end else if (tick) begin
                            bit_d   = (phase_q == MID_PHASE);
                            phase_d = phase_q + PHASE_ONE;
                        end
                    end
                end
            end
            default: begin
                // IDLE: track the divisor input, 0 behaves as 1
                div_d   = (bus.Divisor_i == '0) ? DIV_ONE : bus.Divisor_i;
                cnt_d   = '0;
                phase_d = '0;
            end
        endcase
    end

    assign bus.AcqSig_o  = acq_q;
    assign bus.BitSig_o  = bit_q;
    assign bus.Phase_o   = phase_q;
    assign bus.Aligned_o = aligned_q;

endmodule

// File: tb/tb_rx_baud_gen.sv
module tb_rx_baud_gen;
    localparam int DIV_W   = 16;
    localparam int OS      = 16;
    localparam int PHASE_W = 4;
    localparam int MAXE    = 16384;
    localparam int M_IDLE = 0, M_FREE = 1, M_ALIGNED = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_baud_if #(.DIV_W(DIV_W), .PHASE_W(PHASE_W)) bus ();

    rx_baud_gen #(.DIV_W(DIV_W), .OVERSAMPLE(OS), .PHASE_W(PHASE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int   edge_no;
        logic acq;
        logic bitsig;
        int   phase;
        logic aligned;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_printed = 0;
    int edge_no = 0;

    // reference model state: mode, latched divisor, cycles since the last anchor
    int     m_mode = M_IDLE;
    int     m_div  = 1;
    longint m_el   = 0;

    // observed outputs per edge
    bit acq_log [MAXE];
    bit bit_log [MAXE];
    int ph_log  [MAXE];
    bit al_log  [MAXE];

    // Outputs after one clock edge, from elapsed time since enable/resync.
    task automatic model_step(input logic r, input logic en, input int div,
                              input logic res, input logic halt, output exp_t e);
        longint ticks;
        e.edge_no = edge_no;
        e.acq = 1'b0; e.bitsig = 1'b0; e.phase = 0; e.aligned = 1'b0;
        if (r) begin
            m_mode = M_IDLE; m_div = 1; m_el = 0;
        end else if (m_mode == M_IDLE) begin
            m_div = (div == 0) ? 1 : div;
            if (en) begin m_mode = M_FREE; m_el = 0; end
        end else if (!en) begin
            m_mode = M_IDLE;
        end else if (res) begin
            m_mode = M_ALIGNED; m_el = 0; e.aligned = 1'b1;
        end else begin
            m_el++;
            e.acq = ((m_el % m_div) == 0);
            if (m_mode == M_ALIGNED && halt) begin
                m_mode = M_FREE;
            end else if (m_mode == M_ALIGNED) begin
                ticks     = m_el / m_div;
                e.phase   = int'(ticks % OS);
                e.bitsig  = e.acq && ((ticks % OS) == OS/2);
                e.aligned = 1'b1;
            end
        end
    endtask

    task automatic step(input logic r, input logic en, input int div,
                        input logic res, input logic halt);
        exp_t e;
        @(negedge clk);
        rst           = r;
        bus.Enable_i  = en;
        bus.Divisor_i = div[DIV_W-1:0];
        bus.Resync_i  = res;
        bus.Halt_i    = halt;
        model_step(r, en, div, res, halt, e);
        exp_q.push_back(e);
        edge_no++;
    endtask

    task automatic run(input int n, input int div);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, div, 1'b0, 1'b0);
    endtask

    // wait until the monitor has consumed everything pushed so far
    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int count_acq(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) c += int'(acq_log[i]);
        return c;
    endfunction

    function automatic int count_bit(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) c += int'(bit_log[i]);
        return c;
    endfunction

    // Scoreboard monitor: one expected entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.edge_no < MAXE) begin
                    acq_log[e.edge_no] = bus.AcqSig_o;
                    bit_log[e.edge_no] = bus.BitSig_o;
                    ph_log[e.edge_no]  = int'(bus.Phase_o);
                    al_log[e.edge_no]  = bus.Aligned_o;
                end
                n_checks++;
                if (bus.AcqSig_o !== e.acq || bus.BitSig_o !== e.bitsig ||
                    int'(bus.Phase_o) != e.phase || bus.Aligned_o !== e.aligned) begin
                    n_errors++;
                    if (n_printed < 40) begin
                        n_printed++;
                        $display("FAIL scoreboard edge %0d: got acq=%b bit=%b phase=%0d aligned=%b, expected acq=%b bit=%b phase=%0d aligned=%b",
                                 e.edge_no, bus.AcqSig_o, bus.BitSig_o, int'(bus.Phase_o), bus.Aligned_o,
                                 e.acq, e.bitsig, e.phase, e.aligned);
                    end
                end
            end
        end
    end

    initial begin
        int e0, r, r2, h, x;
        bus.Enable_i = 1'b0; bus.Divisor_i = '0; bus.Resync_i = 1'b0; bus.Halt_i = 1'b0;

        // 1: reset, then free-running with divisor 4
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4, 1'b0, 1'b0);
        x = edge_no - 1;
        e0 = edge_no;
        step(1'b0, 1'b1, 4, 1'b0, 1'b0);
        run(40, 4);
        drain();
        chk("reset_outputs", {acq_log[x], bit_log[x], al_log[x]} + ph_log[x], 0);
        chk("free_first_tick", acq_log[e0+4], 1);
        chk("free_no_early_tick", count_acq(e0, e0+3), 0);
        chk("free_tick_count", count_acq(e0+1, e0+40), 10);
        chk("free_no_bit", count_bit(e0, e0+40), 0);
        $display("scenario 1 free-run div4 done at edge %0d", edge_no);

        // 2: resync with divisor 4
        r = edge_no;
        step(1'b0, 1'b1, 4, 1'b1, 1'b0);
        run(170, 4);
        drain();
        chk("resync_first_tick", acq_log[r+4], 1);
        chk("resync_bit_1", bit_log[r+32], 1);
        chk("resync_bit_2", bit_log[r+96], 1);
        chk("resync_bit_3", bit_log[r+160], 1);
        chk("resync_bit_count", count_bit(r, r+170), 3);
        chk("resync_phase8", ph_log[r+33], 8);
        $display("scenario 2 resync div4 done at edge %0d", edge_no);

        // 3: divisor 0 behaves as 1
        step(1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0, 1'b0);
        e0 = edge_no;
        step(1'b0, 1'b1, 0, 1'b0, 1'b0);
        run(10, 0);
        r = edge_no;
        step(1'b0, 1'b1, 0, 1'b1, 1'b0);
        run(30, 0);
        drain();
        chk("div0_every_clock", count_acq(e0+1, e0+10), 10);
        chk("div0_bit_1", bit_log[r+8], 1);
        chk("div0_bit_2", bit_log[r+24], 1);
        chk("div0_bit_count", count_bit(r, r+30), 2);
        $display("scenario 3 divisor 0 done at edge %0d", edge_no);

        // 4: resync coincident with a tick, divisor 4
        step(1'b0, 1'b0, 4, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4, 1'b1, 1'b0);
        run(10, 4);
        for (int i = 0; i < 8 && ((m_el + 1) % m_div) != 0; i++) step(1'b0, 1'b1, 4, 1'b0, 1'b0);
        r2 = edge_no;
        step(1'b0, 1'b1, 4, 1'b1, 1'b0);
        run(12, 4);
        drain();
        chk("coinc_prev_tick", acq_log[r2-4], 1);
        chk("coinc_tick_suppressed", acq_log[r2], 0);
        chk("coinc_phase0", ph_log[r2], 0);
        chk("coinc_gap", count_acq(r2+1, r2+3), 0);
        chk("coinc_next_tick", acq_log[r2+4], 1);
        chk("coinc_next_phase", ph_log[r2+4], 1);
        $display("scenario 4 resync on tick done at edge %0d", edge_no);

        // 5: halt in ALIGNED, divisor change ignored until IDLE
        h = edge_no;
        step(1'b0, 1'b1, 8, 1'b0, 1'b1);
        run(80, 8);
        drain();
        chk("halt_unaligned", al_log[h], 0);
        chk("halt_no_bits", count_bit(h, h+80), 0);
        chk("halt_period_stays4", count_acq(h+1, h+80), 20);
        step(1'b0, 1'b0, 8, 1'b0, 1'b0);
        e0 = edge_no;
        step(1'b0, 1'b1, 8, 1'b0, 1'b0);
        run(40, 8);
        drain();
        chk("newdiv_first_tick", acq_log[e0+8], 1);
        chk("newdiv_count", count_acq(e0+1, e0+40), 5);
        $display("scenario 5 halt and divisor latch done at edge %0d", edge_no);

        // 6: rst and Enable_i=0 mid-bit
        step(1'b0, 1'b1, 8, 1'b1, 1'b0);
        run(21, 8);
        x = edge_no;
        step(1'b1, 1'b1, 5, 1'b0, 1'b0);
        e0 = edge_no;
        step(1'b0, 1'b1, 5, 1'b0, 1'b0);
        run(12, 5);
        step(1'b0, 1'b1, 5, 1'b1, 1'b0);
        run(13, 5);
        h = edge_no;
        step(1'b0, 1'b0, 3, 1'b0, 1'b0);
        r = edge_no;
        step(1'b0, 1'b1, 3, 1'b0, 1'b0);
        run(10, 3);
        drain();
        chk("rst_mid_outputs", {acq_log[x], bit_log[x], al_log[x]} + ph_log[x], 0);
        chk("rst_restart_tick", acq_log[e0+5], 1);
        chk("rst_restart_gap", count_acq(e0+1, e0+4), 0);
        chk("dis_mid_outputs", {acq_log[h], bit_log[h], al_log[h]} + ph_log[h], 0);
        chk("dis_restart_tick", acq_log[r+3], 1);
        chk("dis_restart_gap", count_acq(r, r+2), 0);
        $display("scenario 6 reset/disable mid-bit done at edge %0d", edge_no);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 600) == 0, ($urandom % 80) != 0, int'($urandom % 6),
                 ($urandom % 40) == 0, ($urandom % 30) == 0);
        end
        drain();
        $display("random phase done at edge %0d", edge_no);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
